// File: rtl/nand_phy_rd_capture_if.sv
// Read-capture bus: IDDR-sampled DQ/DQS inputs, read command, and the
// valid/ready word stream plus status flags back to the controller.
interface nand_phy_rd_capture_if;
  logic [7:0]  v_dq_rise;
  logic [7:0]  v_dq_fall;
  logic        v_dqs_rise;
  logic        v_dqs_fall;
  logic        v_rd_start;
  logic [15:0] v_rd_words;
  logic [15:0] v_rd_data;
  logic        v_rd_valid;
  logic        v_rd_ready;
  logic        v_rd_busy;
  logic        v_rd_done;
  logic        v_rd_tmo;
  logic        v_rd_ovf;

  // Controller / stimulus side
  modport master (
    output v_dq_rise, v_dq_fall, v_dqs_rise, v_dqs_fall,
    output v_rd_start, v_rd_words, v_rd_ready,
    input  v_rd_data, v_rd_valid, v_rd_busy, v_rd_done, v_rd_tmo, v_rd_ovf
  );

  // Capture block side
  modport slave (
    input  v_dq_rise, v_dq_fall, v_dqs_rise, v_dqs_fall,
    input  v_rd_start, v_rd_words, v_rd_ready,
    output v_rd_data, v_rd_valid, v_rd_busy, v_rd_done, v_rd_tmo, v_rd_ovf
  );
endinterface

// File: rtl/nand_phy_rd_capture.sv
// NAND PHY read capture: counts DQS beats of a read burst, packs each
// beat's {fall, rise} DQ bytes into a 16-bit word, and buffers the words
// in a small FIFO drained through a valid/ready port. Aborts on DQS
// silence longer than TMO_CYCLES and flags words lost to a full FIFO.
module nand_phy_rd_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int TMO_CYCLES = 64
) (
  input  logic                  v_clk0,
  input  logic                  v_rst0,
  nand_phy_rd_capture_if.slave  bus
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              TW       = $clog2(TMO_CYCLES + 1);
  localparam logic [AW:0]     DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t        state_q;
  logic [15:0]   cnt_q, cnt_d, words_q;
  logic [TW-1:0] idle_q;
  logic          tmo_q, ovf_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   occ_q;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic beat, cap_beat, valid, full, pop, push, drop;

  // A beat is a clean DQS rising half with the falling half low.
  assign beat     = bus.v_dqs_rise & ~bus.v_dqs_fall;
  assign cap_beat = (state_q == CAPTURE) & beat;
  assign valid    = (occ_q != '0);
  assign full     = (occ_q == DEPTH_C);
  assign pop      = valid & bus.v_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
  assign push     = cap_beat & (~full | pop);
  assign drop     = cap_beat & full & ~pop;
  assign cnt_d    = cnt_q + 16'd1;

  // Read sequencer: start/complete/timeout plus sticky status flags.
  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      words_q <= '0;
      idle_q  <= '0;
      tmo_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.v_rd_start) begin
          tmo_q   <= 1'b0;
          ovf_q   <= 1'b0;
          cnt_q   <= '0;
          idle_q  <= '0;
          words_q <= bus.v_rd_words;
          state_q <= (bus.v_rd_words == '0) ? DONE : CAPTURE;
        end
        CAPTURE: begin
          if (beat) begin
            // Dropped words still count toward the burst length.
            cnt_q  <= cnt_d;
            idle_q <= '0;
            if (drop) ovf_q <= 1'b1;
            if (cnt_d == words_q) state_q <= DONE;
          end else if (idle_q == TMO_LAST) begin
            tmo_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idle_q <= idle_q + TW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Word storage; contents are don't-care until marked valid by occupancy.
  always_ff @(posedge v_clk0) begin
    if (push) mem_q[wr_q] <= {bus.v_dq_fall, bus.v_dq_rise};
  end

  assign bus.v_rd_valid = valid;
  assign bus.v_rd_data  = valid ? mem_q[rd_q] : 16'h0000;
  assign bus.v_rd_busy  = (state_q != IDLE);
  assign bus.v_rd_done  = (state_q == DONE);
  assign bus.v_rd_tmo   = tmo_q;
  assign bus.v_rd_ovf   = ovf_q;
endmodule
